// File: rtl/piece_sequencer_pkg.sv
// Shared types and constants for the falling-block game-flow controller.
// Optional feature macro: HARD_DROP_EN (adds the space-bar hard drop and S_HDROP).
package piece_sequencer_pkg;

    // Bit positions inside can_move / move_cmd
    typedef enum logic [2:0] {
        MV_LEFT  = 3'd0,
        MV_RIGHT = 3'd1,
        MV_DOWN  = 3'd2,
        MV_ROTL  = 3'd3,
        MV_ROTR  = 3'd4
    } move_bit_t;

    // HID usage codes of the keys the game reacts to
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_ROTR  = 8'h52;
    localparam logic [7:0] KEY_ROTL  = 8'h1D;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    typedef enum logic [3:0] {
        S_SPAWN     = 4'd0,
        S_SPAWN_CHK = 4'd1,
        S_WAIT      = 4'd2,
        S_INPUT     = 4'd3,
        S_BUSY1     = 4'd4,
        S_BUSY2     = 4'd5,
        S_GRAVITY   = 4'd6,
        S_LOCKCHK   = 4'd7,
        S_OVER      = 4'd8
`ifdef HARD_DROP_EN
        , S_HDROP   = 4'd9
`endif
    } seq_state_t;

    // A key counts as held if it shows up in any of the four report bytes
    function automatic logic key_hit(input logic [31:0] kc, input logic [7:0] key);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (kc[i*8 +: 8] == key) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/piece_sequencer_key_repeat.sv
// Delayed auto-shift for one lateral direction: fires on the first held
// frame, again after DAS_FRAMES, then every ARR_FRAMES while still held.
module key_repeat #(
    parameter int DAS_FRAMES = 10,
    parameter int ARR_FRAMES = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic held,
    input  logic frame,
    input  logic clear,
    output logic fire
);
    localparam logic [7:0] DAS_L = 8'(DAS_FRAMES);
    localparam logic [7:0] ARR_L = 8'(ARR_FRAMES - 1);

    logic [7:0] das_cnt;
    logic [7:0] arr_cnt;

    // Fire on the initial press, then on each auto-repeat slot once charged
    always_comb begin
        fire = frame && held && !clear &&
               ((das_cnt == 8'd0) || ((das_cnt == DAS_L) && (arr_cnt == 8'd0)));
    end

    // Count held frames; releasing or a conflicting key restarts the delay
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            das_cnt <= 8'd0;
            arr_cnt <= 8'd0;
        end else if (frame) begin
            if (!held || clear) begin
                das_cnt <= 8'd0;
                arr_cnt <= 8'd0;
            end else if (das_cnt < DAS_L) begin
                das_cnt <= das_cnt + 8'd1;
            end else begin
                arr_cnt <= (arr_cnt >= ARR_L) ? 8'd0 : arr_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/piece_sequencer.sv
// Game-flow controller: per frame turns keys and gravity into at most one
// move plus one down command, handles lock delay, spawning and game over.
// Optional feature macro: HARD_DROP_EN (space bar drops and locks at once).
module piece_sequencer
    import piece_sequencer_pkg::*;
#(
    parameter int GRAVITY_FRAMES   = 48,
    parameter int SOFT_DROP_FRAMES = 3,
    parameter int DAS_FRAMES       = 10,
    parameter int ARR_FRAMES       = 4,
    parameter int LOCK_FRAMES      = 30,
    parameter int LOCK_RESETS      = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk_rising_edge,
    input  logic [31:0] keycode,
    input  logic [4:0]  can_move,
    input  logic        BOARD_BUSY,
    output logic [4:0]  move_cmd,
    output logic        get_new_block,
    output logic        lock_piece,
    output logic        game_over
);
    localparam logic [7:0] GRAV_L   = 8'(GRAVITY_FRAMES);
    localparam logic [7:0] SOFT_L   = 8'(SOFT_DROP_FRAMES);
    localparam logic [7:0] LOCK_L   = 8'(LOCK_FRAMES);
    localparam logic [7:0] RESETS_L = 8'(LOCK_RESETS);

    seq_state_t state, state_nxt;
    logic       frame_pending;
    logic [7:0] gravity_cnt, lock_cnt, resets_used;
    logic       prev_rotr, prev_rotl;
    logic       bw_rose;
    logic [1:0] bw_cnt;
    logic       bw_active, bw_done, bw_timeout_en;

    logic [4:0] mv_nxt, sel;
    logic       gnb_nxt, lock_nxt, over_set;
    logic       g_inc, g_clr, l_inc, l_clr, r_inc, cnt_clr;
    logic [7:0] period;

    logic k_left, k_right, k_down, k_rotr, k_rotl;
    logic rotr_edge, rotl_edge, lr_both, in_input, enter_input;
    logic fire_left, fire_right;

`ifdef HARD_DROP_EN
    logic prev_hd, k_hd, hd_edge, hd_wait, hd_wait_set, hd_wait_clr;
    assign k_hd    = key_hit(keycode, KEY_SPACE);
    assign hd_edge = k_hd && !prev_hd;
`endif

    assign k_left    = key_hit(keycode, KEY_LEFT);
    assign k_right   = key_hit(keycode, KEY_RIGHT);
    assign k_down    = key_hit(keycode, KEY_DOWN);
    assign k_rotr    = key_hit(keycode, KEY_ROTR);
    assign k_rotl    = key_hit(keycode, KEY_ROTL);
    assign rotr_edge = k_rotr && !prev_rotr;
    assign rotl_edge = k_rotl && !prev_rotl;
    assign lr_both   = k_left && k_right;
    assign in_input  = (state == S_INPUT);
    assign enter_input = (state_nxt == S_INPUT) && (state != S_INPUT);
    assign period    = k_down ? SOFT_L : GRAV_L;

    key_repeat #(.DAS_FRAMES(DAS_FRAMES), .ARR_FRAMES(ARR_FRAMES)) u_rep_left (
        .Clk(Clk), .Reset(Reset), .held(k_left), .frame(in_input),
        .clear(lr_both), .fire(fire_left)
    );

    key_repeat #(.DAS_FRAMES(DAS_FRAMES), .ARR_FRAMES(ARR_FRAMES)) u_rep_right (
        .Clk(Clk), .Reset(Reset), .held(k_right), .frame(in_input),
        .clear(lr_both), .fire(fire_right)
    );

    // Board handshake: wait for BOARD_BUSY to rise (bounded except at spawn), then fall
    always_comb begin
        bw_active = (state == S_SPAWN_CHK) || (state == S_BUSY1) || (state == S_BUSY2);
`ifdef HARD_DROP_EN
        bw_active = bw_active || ((state == S_HDROP) && hd_wait);
`endif
        bw_timeout_en = (state != S_SPAWN_CHK);
        bw_done       = bw_active && bw_rose && !BOARD_BUSY;
    end

    // Next-state and command selection
    always_comb begin
        state_nxt = state;
        mv_nxt    = 5'b0;
        sel       = 5'b0;
        gnb_nxt   = 1'b0;
        lock_nxt  = 1'b0;
        over_set  = 1'b0;
        g_inc     = 1'b0;
        g_clr     = 1'b0;
        l_inc     = 1'b0;
        l_clr     = 1'b0;
        r_inc     = 1'b0;
        cnt_clr   = 1'b0;
`ifdef HARD_DROP_EN
        hd_wait_set = 1'b0;
        hd_wait_clr = 1'b0;
`endif
        case (state)
            S_SPAWN: begin
                if (!BOARD_BUSY) begin
                    gnb_nxt   = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = S_SPAWN_CHK;
                end
            end
            S_SPAWN_CHK: begin
                if (bw_done) begin
                    if (can_move == 5'b0) begin
                        over_set  = 1'b1;
                        state_nxt = S_OVER;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (frame_pending) begin
                    g_inc     = 1'b1;
                    state_nxt = S_INPUT;
                end
            end
            S_INPUT: begin
                if (rotr_edge)       sel[MV_ROTR]  = 1'b1;
                else if (rotl_edge)  sel[MV_ROTL]  = 1'b1;
                else if (lr_both)    sel           = 5'b0;
                else if (fire_left)  sel[MV_LEFT]  = 1'b1;
                else if (fire_right) sel[MV_RIGHT] = 1'b1;
`ifdef HARD_DROP_EN
                if (hd_edge) begin
                    sel       = 5'b0;
                    state_nxt = S_HDROP;
                end else
`endif
                if ((sel & can_move) != 5'b0) begin
                    mv_nxt    = sel;
                    state_nxt = S_BUSY1;
                    // A successful move on the ground buys more lock time, a limited number of times
                    if (!can_move[MV_DOWN] && (resets_used < RESETS_L)) begin
                        l_clr = 1'b1;
                        r_inc = 1'b1;
                    end
                end else begin
                    state_nxt = S_GRAVITY;
                end
            end
            S_BUSY1: if (bw_done) state_nxt = S_GRAVITY;
            S_BUSY2: if (bw_done) state_nxt = S_WAIT;
            S_GRAVITY: begin
                if (gravity_cnt >= period) begin
                    g_clr = 1'b1;
                    if (can_move[MV_DOWN]) begin
                        mv_nxt[MV_DOWN] = 1'b1;
                        l_clr           = 1'b1;
                        state_nxt       = S_BUSY2;
                    end else begin
                        state_nxt = S_LOCKCHK;
                    end
                end else begin
                    state_nxt = can_move[MV_DOWN] ? S_WAIT : S_LOCKCHK;
                end
            end
            S_LOCKCHK: begin
                l_inc = 1'b1;
                if ((lock_cnt + 8'd1) == LOCK_L) begin
                    lock_nxt  = 1'b1;
                    state_nxt = S_SPAWN;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_OVER: state_nxt = S_OVER;
`ifdef HARD_DROP_EN
            S_HDROP: begin
                if (hd_wait) begin
                    if (bw_done) hd_wait_clr = 1'b1;
                end else if (!BOARD_BUSY) begin
                    if (can_move[MV_DOWN]) begin
                        mv_nxt[MV_DOWN] = 1'b1;
                        hd_wait_set     = 1'b1;
                    end else begin
                        lock_nxt  = 1'b1;
                        state_nxt = S_SPAWN;
                    end
                end
            end
`endif
            default: state_nxt = S_SPAWN;
        endcase
    end

    // State, registered command pulses and sticky game over
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state         <= S_SPAWN;
            move_cmd      <= 5'b0;
            get_new_block <= 1'b0;
            lock_piece    <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            state         <= state_nxt;
            move_cmd      <= mv_nxt;
            get_new_block <= gnb_nxt;
            lock_piece    <= lock_nxt;
            game_over     <= game_over | over_set;
        end
    end

    // Frame tick latch; a new tick wins over the clear on S_INPUT entry
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) frame_pending <= 1'b0;
        else       frame_pending <= frame_clk_rising_edge | (frame_pending & ~enter_input);
    end

    // Gravity, lock-delay and lock-reset counters
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            gravity_cnt <= 8'd0;
            lock_cnt    <= 8'd0;
            resets_used <= 8'd0;
        end else if (cnt_clr) begin
            gravity_cnt <= 8'd0;
            lock_cnt    <= 8'd0;
            resets_used <= 8'd0;
        end else begin
            if (g_clr)                              gravity_cnt <= 8'd0;
            else if (g_inc && gravity_cnt != 8'hFF) gravity_cnt <= gravity_cnt + 8'd1;
            if (l_clr)      lock_cnt <= 8'd0;
            else if (l_inc) lock_cnt <= lock_cnt + 8'd1;
            if (r_inc)      resets_used <= resets_used + 8'd1;
        end
    end

    // Previous-frame key flags for edge-triggered rotation
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prev_rotr <= 1'b0;
            prev_rotl <= 1'b0;
        end else if (in_input) begin
            prev_rotr <= k_rotr;
            prev_rotl <= k_rotl;
        end
    end

    // Board handshake progress: rise seen (or timed out), cycles waited
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bw_rose <= 1'b0;
            bw_cnt  <= 2'd0;
        end else if (!bw_active || bw_done || (state_nxt != state)) begin
            bw_rose <= 1'b0;
            bw_cnt  <= 2'd0;
        end else if (!bw_rose) begin
            if (BOARD_BUSY)                               bw_rose <= 1'b1;
            else if (bw_timeout_en && (bw_cnt == 2'd3))   bw_rose <= 1'b1;
            else                                          bw_cnt  <= bw_cnt + 2'd1;
        end
    end

`ifdef HARD_DROP_EN
    // Hard drop: space edge flag and per-step board wait
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prev_hd <= 1'b0;
            hd_wait <= 1'b0;
        end else begin
            if (in_input)         prev_hd <= k_hd;
            if (state != S_HDROP) hd_wait <= 1'b0;
            else if (hd_wait_set) hd_wait <= 1'b1;
            else if (hd_wait_clr) hd_wait <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_piece_sequencer.sv
// Scoreboard bench: expected pulses (with the frame they belong to) are queued
// up front; a monitor pops and compares whenever the DUT emits a pulse.
module tb_piece_sequencer;
    import piece_sequencer_pkg::*;

    localparam int FRAME_CYC = 24;

    localparam logic [6:0] EV_LEFT = 7'b0000001;
    localparam logic [6:0] EV_DOWN = 7'b0000100;
    localparam logic [6:0] EV_ROTR = 7'b0010000;
    localparam logic [6:0] EV_GNB  = 7'b0100000;
    localparam logic [6:0] EV_LOCK = 7'b1000000;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk_rising_edge;
    logic [31:0] keycode;
    logic [4:0]  can_move;
    logic        BOARD_BUSY;
    logic [4:0]  move_cmd;
    logic        get_new_block;
    logic        lock_piece;
    logic        game_over;

    typedef struct {
        logic [6:0] ev;
        int         frame;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   frame_no    = 0;
    logic [6:0] mon_got;
    exp_t       mon_e;

    piece_sequencer dut (
        .Clk(Clk), .Reset(Reset), .frame_clk_rising_edge(frame_clk_rising_edge),
        .keycode(keycode), .can_move(can_move), .BOARD_BUSY(BOARD_BUSY),
        .move_cmd(move_cmd), .get_new_block(get_new_block),
        .lock_piece(lock_piece), .game_over(game_over)
    );

    always #5 Clk = ~Clk;

    // Monitor: every pulse must match the head of the expectation queue
    initial begin
        forever begin
            @(negedge Clk);
            if (Reset !== 1'b1 && (move_cmd != 5'b0 || get_new_block || lock_piece)) begin
                mon_got = {lock_piece, get_new_block, move_cmd};
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_pulse: got %b at frame %0d, required no pulse", mon_got, frame_no);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.ev !== mon_got || mon_e.frame != frame_no) begin
                        miscompares++;
                        $display("FAIL pulse: got %b at frame %0d, required %b at frame %0d",
                                 mon_got, frame_no, mon_e.ev, mon_e.frame);
                    end
                end
            end
        end
    end

    // Board model: busy for three cycles after each command or spawn request
    initial begin
        int bcnt;
        bcnt = 0;
        BOARD_BUSY = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            if (Reset === 1'b1) begin
                bcnt = 0;
                BOARD_BUSY = 1'b0;
            end else if (move_cmd != 5'b0 || get_new_block) begin
                bcnt = 3;
                BOARD_BUSY = 1'b1;
            end else if (bcnt > 1) begin
                bcnt--;
            end else begin
                bcnt = 0;
                BOARD_BUSY = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [6:0] ev, input int f);
        exp_t e;
        e.ev = ev;
        e.frame = f;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    // All queued pulses must have been seen by now
    task automatic drained(input string name);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s: %0d expected pulses missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic frame(input logic [31:0] kc);
        keycode = kc;
        @(posedge Clk); #1;
        frame_clk_rising_edge = 1'b1;
        frame_no++;
        @(posedge Clk); #1;
        frame_clk_rising_edge = 1'b0;
        repeat (FRAME_CYC) @(posedge Clk);
        #1;
    endtask

    task automatic do_reset(input logic [4:0] cm);
        @(posedge Clk); #1;
        Reset = 1'b1;
        keycode = 32'h0;
        frame_clk_rising_edge = 1'b0;
        can_move = cm;
        frame_no = 0;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_outputs", {25'b0, move_cmd, get_new_block, lock_piece}, 32'h0);
        push(EV_GNB, 0);
        Reset = 1'b0;
        repeat (20) @(posedge Clk);
        #1;
        drained("spawn");
    endtask

    initial begin
        Reset = 1'b1;
        keycode = 32'h0;
        frame_clk_rising_edge = 1'b0;
        can_move = 5'h1F;

        // Plain gravity: first down step on frame 48
        do_reset(5'h1F);
        chk("game_over_idle", {31'b0, game_over}, 32'h0);
        push(EV_DOWN, 48);
        for (int f = 1; f <= 48; f++) frame(32'h0);
        drained("gravity");

        // LEFT held 30 frames: DAS/ARR slots
        do_reset(5'h1F);
        push(EV_LEFT, 1);  push(EV_LEFT, 11); push(EV_LEFT, 15);
        push(EV_LEFT, 19); push(EV_LEFT, 23); push(EV_LEFT, 27);
        for (int f = 1; f <= 30; f++) frame(32'h0000_0050);
        frame(32'h0);
        drained("das_arr");

        // ROT_R held: one pulse; later blocked rotation gives none
        do_reset(5'h1F);
        push(EV_ROTR, 1);
        for (int f = 1; f <= 10; f++) frame(32'h0052_0000);
        frame(32'h0);
        frame(32'h0);
        can_move = 5'h0F;
        for (int f = 13; f <= 22; f++) frame(32'h0052_0000);
        drained("rotate");

        // LEFT+RIGHT in different bytes: nothing, then LEFT alone fires at once
        do_reset(5'h1F);
        push(EV_LEFT, 21);
        for (int f = 1; f <= 20; f++) frame(32'h5000_004F);
        frame(32'h0000_5000);
        drained("left_right");

        // Soft drop: down every 3 frames
        do_reset(5'h1F);
        push(EV_DOWN, 3); push(EV_DOWN, 6); push(EV_DOWN, 9);
        for (int f = 1; f <= 9; f++) frame(32'h0000_0051);
        drained("soft_drop");

        // Lateral blocked by can_move[0]=0: no pulse
        do_reset(5'h1E);
        for (int f = 1; f <= 12; f++) frame(32'h0000_0050);
        drained("left_blocked");

        // Grounded: lock on frame 30, then respawn
        do_reset(5'h1B);
        push(EV_LOCK, 30); push(EV_GNB, 30);
        for (int f = 1; f <= 30; f++) frame(32'h0);
        drained("lock_delay");

        // Rotating every 2 frames while grounded: 15 resets then lock on frame 58
        do_reset(5'h1B);
        for (int f = 1; f <= 57; f += 2) push(EV_ROTR, f);
        push(EV_LOCK, 58); push(EV_GNB, 58);
        for (int f = 1; f <= 58; f++) frame((f % 2 == 1) ? 32'h0000_0052 : 32'h0);
        drained("lock_resets");

        // Spawn blocked: game over, sticky under key activity
        do_reset(5'h00);
        chk("game_over_set", {31'b0, game_over}, 32'h1);
        for (int f = 1; f <= 5; f++) frame(32'h5052_5100);
        chk("game_over_sticky", {31'b0, game_over}, 32'h1);
        drained("game_over_quiet");

        // Reset clears game over
        do_reset(5'h1F);
        chk("game_over_cleared", {31'b0, game_over}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
